// File: rtl/game_pkg.sv
// Shared game definitions: controller state encodings, per-player FSM states
// and hit damage amounts.
package game_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_COUNTDOWN = 3'd1;
    localparam logic [2:0] S_FIGHT     = 3'd2;
    localparam logic [2:0] S_P1_WIN    = 3'd3;
    localparam logic [2:0] S_P2_WIN    = 3'd4;
    localparam logic [2:0] S_EQ        = 3'd5;

    typedef enum logic [1:0] {
        PH_READY  = 2'd0,
        PH_STUN   = 2'd1,
        PH_IFRAME = 2'd2,
        PH_KO     = 2'd3
    } ph_state_t;

    localparam logic [2:0] LIGHT_DMG = 3'd1;
    localparam logic [2:0] HEAVY_DMG = 3'd2;

endpackage

// File: rtl/player_health_unit.sv
// One fighter: READY/STUN/IFRAME/KO FSM, frame counter, health and KO pulse.
// PLAYER_HEALTH_IFRAME_EN compiles in the post-stun invulnerability state.
module player_health_unit
    import game_pkg::*;
#(
    parameter logic [2:0] MAX_HEALTH    = 3'd5,
    parameter int         STUN_FRAMES   = 20,
    parameter int         IFRAME_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       round_setup,
    input  logic       fight_active,
    input  logic       hit,
    input  logic       heavy,
    input  logic       block,
    output logic [2:0] health,
    output logic       stunned,
    output logic       invuln,
    output logic       ko
);

`ifdef PLAYER_HEALTH_IFRAME_EN
    localparam bit IFRAME_ON = 1'b1;
`else
    localparam bit IFRAME_ON = 1'b0;
`endif

    localparam logic [7:0] STUN_LOAD   = 8'(STUN_FRAMES - 1);
    localparam logic [7:0] IFRAME_LOAD = 8'(IFRAME_FRAMES - 1);
    // Where a finished stun goes; constant-folds to READY when i-frames are off.
    localparam ph_state_t  STUN_EXIT   = IFRAME_ON ? PH_IFRAME : PH_READY;
    localparam logic [7:0] EXIT_LOAD   = IFRAME_ON ? IFRAME_LOAD : 8'd0;

    ph_state_t  state, state_next;
    logic [7:0] cnt, cnt_next;
    logic [2:0] health_next;
    logic       ko_next;
    logic [2:0] dmg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= PH_READY;
            cnt    <= 8'd0;
            health <= MAX_HEALTH;
            ko     <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            health <= health_next;
            ko     <= ko_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        health_next = health;
        ko_next     = 1'b0;
        dmg         = heavy ? HEAVY_DMG : LIGHT_DMG;
        if (block) dmg = dmg - 3'd1;

        if (round_setup) begin
            state_next  = PH_READY;
            cnt_next    = 8'd0;
            health_next = MAX_HEALTH;
        end else if (fight_active) begin
            case (state)
                PH_READY: begin
                    if (hit) begin
                        health_next = (health > dmg) ? health - dmg : 3'd0;
                        // KO wins over stun when the same hit empties health.
                        if (health_next == 3'd0) begin
                            state_next = PH_KO;
                            cnt_next   = 8'd0;
                            ko_next    = 1'b1;
                        end else if (!block) begin
                            state_next = PH_STUN;
                            cnt_next   = STUN_LOAD;
                        end
                    end
                end
                PH_STUN: begin
                    if (cnt == 8'd0) begin
                        state_next = STUN_EXIT;
                        cnt_next   = EXIT_LOAD;
                    end else begin
                        cnt_next = cnt - 8'd1;
                    end
                end
`ifdef PLAYER_HEALTH_IFRAME_EN
                PH_IFRAME: begin
                    if (cnt == 8'd0) state_next = PH_READY;
                    else             cnt_next   = cnt - 8'd1;
                end
`endif
                PH_KO: ;
                default: begin
                    state_next = PH_READY;
                    cnt_next   = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        stunned = (state == PH_STUN);
`ifdef PLAYER_HEALTH_IFRAME_EN
        invuln  = (state == PH_STUN) || (state == PH_IFRAME);
`else
        invuln  = (state == PH_STUN);
`endif
    end

endmodule

// File: rtl/player_health.sv
// Health, hit-stun and invulnerability tracking for both fighters, one frame
// per clock. PLAYER_HEALTH_IFRAME_EN enables post-stun i-frames.
module player_health
    import game_pkg::*;
#(
    parameter logic [2:0] MAX_HEALTH    = 3'd5,
    parameter int         STUN_FRAMES   = 20,
    parameter int         IFRAME_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] game_state,
    input  logic       p1_hit,
    input  logic       p2_hit,
    input  logic       p1_heavy,
    input  logic       p2_heavy,
    input  logic       p1_block,
    input  logic       p2_block,
    output logic [2:0] player1_health,
    output logic [2:0] player2_health,
    output logic       p1_stunned,
    output logic       p2_stunned,
    output logic       p1_invuln,
    output logic       p2_invuln,
    output logic       p1_ko,
    output logic       p2_ko
);

    logic round_setup;
    logic fight_active;

    // Encodings 6 and 7 are unused by the controller and treated as setup.
    assign round_setup  = (game_state == S_IDLE) || (game_state == S_COUNTDOWN) ||
                          (game_state == 3'd6)   || (game_state == 3'd7);
    assign fight_active = (game_state == S_FIGHT);

    player_health_unit #(
        .MAX_HEALTH   (MAX_HEALTH),
        .STUN_FRAMES  (STUN_FRAMES),
        .IFRAME_FRAMES(IFRAME_FRAMES)
    ) u_p1 (
        .clk         (clk),
        .reset       (reset),
        .round_setup (round_setup),
        .fight_active(fight_active),
        .hit         (p1_hit),
        .heavy       (p1_heavy),
        .block       (p1_block),
        .health      (player1_health),
        .stunned     (p1_stunned),
        .invuln      (p1_invuln),
        .ko          (p1_ko)
    );

    player_health_unit #(
        .MAX_HEALTH   (MAX_HEALTH),
        .STUN_FRAMES  (STUN_FRAMES),
        .IFRAME_FRAMES(IFRAME_FRAMES)
    ) u_p2 (
        .clk         (clk),
        .reset       (reset),
        .round_setup (round_setup),
        .fight_active(fight_active),
        .hit         (p2_hit),
        .heavy       (p2_heavy),
        .block       (p2_block),
        .health      (player2_health),
        .stunned     (p2_stunned),
        .invuln      (p2_invuln),
        .ko          (p2_ko)
    );

endmodule

// File: doc/player_health.md
# player_health

Tracks both fighters' health, hit-stun and invulnerability during a round, and feeds the resulting `player1_health` / `player2_health` back to the game-state controller. It sits downstream of the game controller: it consumes `game_state` and the per-player hit events, and produces the health values the controller uses to decide win, lose or draw. It runs on the 60 Hz game clock, so one cycle is one frame.

## Interface
Parameters:
- `MAX_HEALTH`, default 3'd5: health loaded at round start; range 1..7.
- `STUN_FRAMES`, default 20: hit-stun length in cycles; range 1..255.
- `IFRAME_FRAMES`, default 30: post-stun invulnerability length in cycles; range 1..255. Used only with `PLAYER_HEALTH_IFRAME_EN`.

Ports:
- `clk` in 1: 60 Hz game clock.
- `reset` in 1: synchronous, active-high.
- `game_state` in 3: controller state. 0=IDLE, 1=COUNTDOWN, 2=FIGHT, 3=P1_WIN, 4=P2_WIN, 5=EQ.
- `p1_hit`, `p2_hit` in 1 each: single-cycle pulse meaning that player was struck this frame.
- `p1_heavy`, `p2_heavy` in 1 each: qualifies the hit; 1 means heavy.
- `p1_block`, `p2_block` in 1 each: that player is blocking, sampled together with the hit.
- `player1_health`, `player2_health` out 3 each: current health.
- `p1_stunned`, `p2_stunned` out 1 each: high while that player is in hit-stun.
- `p1_invuln`, `p2_invuln` out 1 each: high during stun or i-frames; hits are ignored while high.
- `p1_ko`, `p2_ko` out 1 each: one-cycle pulse on the transition of that player's health to 0.

## Operation
- Each player has an independent FSM: READY, STUN, IFRAME, KO.
- Round setup: when `game_state` is IDLE, COUNTDOWN, 6 or 7:
  - health is loaded with `MAX_HEALTH`, FSM goes to READY, counters are cleared.
  - hit inputs are ignored.
- Hit handling applies only when `game_state` = FIGHT.
- A hit is accepted only in READY.
- Raw damage: heavy = 2, light = 1.
- Blocked hit:
  - damage = raw damage − 1, so light blocked = 0 and heavy blocked = 1.
  - no stun; FSM stays in READY.
- Unblocked hit:
  - damage = raw damage.
  - FSM goes to STUN and the counter loads `STUN_FRAMES`−1.
- Health subtraction saturates at 0. No wrap: health 1 with a heavy hit gives 0.
- Health reaching 0 moves the FSM to KO and emits a single `pX_ko` pulse.
  - KO overrides STUN.
  - KO holds until a round-setup state.
- STUN:
  - the counter decrements each FIGHT cycle.
  - at 0 the FSM goes to IFRAME (counter loads `IFRAME_FRAMES`−1) when the macro is defined, otherwise to READY.
- IFRAME: the counter decrements each FIGHT cycle; at 0 the FSM goes to READY.
- Hits during STUN, IFRAME or KO are dropped. They are not queued.
- P1_WIN, P2_WIN, EQ: all state, counters and health are frozen; hits are ignored.
- Simultaneous `p1_hit` and `p2_hit` in the same cycle are both applied. Both players can reach 0 in the same cycle, which lets the controller detect a draw.
- Outputs are registered.
  - `pX_stunned` = (FSM == STUN).
  - `pX_invuln` = (FSM ∈ {STUN, IFRAME}).
- Reset values: health = `MAX_HEALTH`; FSM = READY; all flags and counters = 0.

## Timing
- Hit accepted at edge N; the new health, `pX_stunned` and `pX_ko` are visible after edge N+1. Latency is one cycle.
- `pX_stunned` stays high for exactly `STUN_FRAMES` cycles.
- `pX_invuln` stays high for `STUN_FRAMES` + `IFRAME_FRAMES` cycles with the macro defined, and `STUN_FRAMES` cycles without it.
- The first hit that can be accepted after a stun is the one presented in the first cycle READY is visible.
- Entering a round-setup state restores health in the next cycle. This is regardless of current FSM or counter value.
- Reset mid-round takes effect at the next edge and overrides every other input.

## Configuration
- `PLAYER_HEALTH_IFRAME_EN`:
  - Defined: the IFRAME state and `IFRAME_FRAMES` are compiled in; STUN exits to IFRAME.
  - Undefined: IFRAME logic is removed; STUN exits directly to READY; `pX_invuln` equals `pX_stunned`.

## Structure
- Shared package `game_pkg` holds:
  - the `game_state` encodings (S_IDLE..S_EQ).
  - the player FSM state typedef.
  - the damage constants (LIGHT_DMG = 1, HEAVY_DMG = 2).
- Sub-module `player_health_unit` handles one player: FSM, counter, health register and KO pulse.
  - The top instantiates it twice and decodes `game_state` once into `round_setup` and `fight_active` strobes.

## Test plan
- Reset, then IDLE→COUNTDOWN: both healths = 5, all flags 0, no KO pulse.
- FIGHT, unblocked light `p1_hit` → `player1_health` 5→4 after one cycle; `p1_stunned` high for 20 cycles; with the macro, `p1_invuln` high for 50 cycles. A second hit at cycle 10 is ignored (health stays 4).
- FIGHT, blocked heavy hit on p2 → health 5→4, `p2_stunned` stays 0. Blocked light hit → health unchanged.
- p1 at health 1, heavy hit → health 0 (saturated), one-cycle `p1_ko`. Later hits are ignored. COUNTDOWN restores 5.
- Both at health 1, simultaneous unblocked hits → both 0, both KO pulses in the same cycle.
- Mid-stun, state changes to P1_WIN for 10 cycles then returns to FIGHT → stun resumes with the remaining count; health is unchanged during the freeze.
